// File: rtl/multi_issue_if.sv
// ---------------------------------------------------------------------------
// multi_issue_if
// Bundles every handshake/bus signal of the multi_issue operand sequencer.
//   in_*   : operand-pair push channel (valid/ready) from the producer
//   mul_*  : level-held start/valid link to the multi_vl multiplier
//   out_*  : single-entry result channel (valid/ready) to the consumer
//   busy   : sequencer activity flag
// Modports:
//   master : the sequencer itself (drives in_ready, mul_*, out_*, busy)
//   slave  : the surrounding environment (producer, multiplier, consumer)
// ---------------------------------------------------------------------------
interface multi_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mlier;
  logic [31:0] in_mcand;
  logic        mul_start;
  logic [31:0] mul_mlier;
  logic [31:0] mul_mcand;
  logic [63:0] mul_prodt;
  logic        mul_valid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prodt;
  logic        out_err;
  logic        busy;

  modport master (
    input  in_valid, in_mlier, in_mcand, mul_prodt, mul_valid, out_ready,
    output in_ready, mul_start, mul_mlier, mul_mcand, out_valid, out_prodt,
           out_err, busy
  );

  modport slave (
    output in_valid, in_mlier, in_mcand, mul_prodt, mul_valid, out_ready,
    input  in_ready, mul_start, mul_mlier, mul_mcand, out_valid, out_prodt,
           out_err, busy
  );
endinterface

// File: rtl/multi_issue.sv
// ---------------------------------------------------------------------------
// multi_issue
// Operand sequencer in front of the variable-latency multiplier multi_vl.
// Operand pairs are buffered in a DEPTH-entry FIFO, issued one at a time
// over the level-held mul_start/mul_valid handshake, and each product is
// captured into a single-entry result register (out_valid/out_ready).
// An operation that sees no mul_valid within TIMEOUT cycles is abandoned and
// reported with out_err=1 and out_prodt=0.
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : multi_issue_if.master (push channel, multiplier link, result
//           channel, busy)
// ---------------------------------------------------------------------------
module multi_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic         clock,
  input  logic         reset,
  multi_issue_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Operand storage: {mlier, mcand} per entry, no reset needed.
  logic [63:0] fifo_mem [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            mul_start_q, mul_start_d;
  logic [31:0]     mul_mlier_q, mul_mlier_d;
  logic [31:0]     mul_mcand_q, mul_mcand_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_prodt_q, out_prodt_d;
  logic            out_err_q, out_err_d;

  logic            in_ready_w;
  logic            push_w;
  logic            pop_w;
  logic [63:0]     head_w;
  logic [TW-1:0]   timer_inc_w;

  // Acceptance depends on occupancy alone, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign in_ready_w  = (count_q < CW'(DEPTH));
  assign push_w      = bus.in_valid & in_ready_w;
  assign head_w      = fifo_mem[rd_ptr_q];
  assign timer_inc_w = timer_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    timer_d     = timer_q;
    mul_start_d = mul_start_q;
    mul_mlier_d = mul_mlier_q;
    mul_mcand_d = mul_mcand_q;
    out_valid_d = out_valid_q;
    out_prodt_d = out_prodt_q;
    out_err_d   = out_err_q;
    pop_w       = 1'b0;

    // Consumer handshake empties the result register; a capture below in
    // the same cycle overrides this.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Issue only when the result slot is free or being freed now, so a
        // held result can never be overwritten.
        if ((count_q != '0) && (!out_valid_q || bus.out_ready)) begin
          pop_w       = 1'b1;
          mul_mlier_d = head_w[63:32];
          mul_mcand_d = head_w[31:0];
          timer_d     = '0;
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_inc_w;
        if (bus.mul_valid) begin
          // A product arriving on the timeout cycle still wins.
          out_prodt_d = bus.mul_prodt;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          mul_start_d = 1'b0;
          state_d     = GAP;
        end else if (timer_inc_w == TW'(TIMEOUT)) begin
          out_prodt_d = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          mul_start_d = 1'b0;
          state_d     = GAP;
        end
      end
      GAP: begin
        // Keep start low until the multiplier has dropped its valid, so the
        // next operation cannot see a stale done.
        if (!bus.mul_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        mul_start_d = 1'b0;
      end
    endcase

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_w) begin
      fifo_mem[wr_ptr_q] <= {bus.in_mlier, bus.in_mcand};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      mul_start_q <= 1'b0;
      mul_mlier_q <= '0;
      mul_mcand_q <= '0;
      out_valid_q <= 1'b0;
      out_prodt_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      mul_start_q <= mul_start_d;
      mul_mlier_q <= mul_mlier_d;
      mul_mcand_q <= mul_mcand_d;
      out_valid_q <= out_valid_d;
      out_prodt_q <= out_prodt_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_mlier = mul_mlier_q;
  assign bus.mul_mcand = mul_mcand_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prodt = out_prodt_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: doc/multi_issue.md
# multi_issue

Operand sequencer that sits directly upstream of the variable-latency multiplier `multi_vl` and also collects its results. It buffers operand pairs in a small FIFO and issues them one at a time over the multiplier's level-held `start`/`valid` handshake. It captures each 64-bit product into a single-entry output register with a valid/ready handshake, and flags a multiplier that never answers.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 40: cycles `mul_start` may stay high without `mul_valid` before the operation is abandoned; must exceed the 33-cycle worst-case multiplier latency.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO can accept; high iff count < `DEPTH`.
- `in_mlier` in 32: multiplier operand.
- `in_mcand` in 32: multiplicand operand.
- `mul_start` out 1: start to `multi_vl`, held high for the whole operation.
- `mul_mlier` out 32: registered operand to `multi_vl`, stable while `mul_start` is high.
- `mul_mcand` out 32: registered operand to `multi_vl`, stable while `mul_start` is high.
- `mul_prodt` in 64: product from `multi_vl`.
- `mul_valid` in 1: done from `multi_vl`.
- `out_valid` out 1: result register full.
- `out_ready` in 1: consumer accepts the result.
- `out_prodt` out 64: captured product; 0 on timeout.
- `out_err` out 1: this result timed out; qualified by `out_valid`.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- **FIFO**
  - Push on `in_valid & in_ready`.
  - `in_ready` depends on count only: when full, no push is accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo `DEPTH`.
- **State machine: IDLE, ISSUE, GAP**
  - IDLE: `mul_start`=0. When the FIFO is non-empty and (`out_valid`=0 or `out_ready`=1), pop the head into `mul_mlier`/`mul_mcand`, clear the timer and go to ISSUE.
  - ISSUE: `mul_start`=1 and the timer increments each cycle.
    - On the first cycle with `mul_valid`=1: capture `mul_prodt` into `out_prodt`, set `out_valid`=1 and `out_err`=0, then go to GAP.
    - Otherwise, when the timer reaches `TIMEOUT`: set `out_prodt`=0, `out_err`=1, `out_valid`=1, then go to GAP.
    - `mul_valid` takes priority if both occur in the same cycle.
  - GAP: `mul_start`=0 for at least one cycle. Stay in GAP while `mul_valid`=1; go to IDLE when `mul_valid`=0.
- **Output register**
  - Cleared (`out_valid`→0) on `out_valid & out_ready` unless it is reloaded in the same cycle.
  - Never overwritten while `out_valid & !out_ready`, which the IDLE issue condition guarantees.
- **Operand passing:** operands are passed through unmodified. Signedness of the product is entirely `multi_vl`'s; no width or sign conversion is done here.
- `mul_mlier`/`mul_mcand` hold their last value outside ISSUE.

## Timing
- **Reset** (`reset`=0, asynchronous): state=IDLE and FIFO empty. Outputs: `in_ready`=1; `mul_start`=0; `mul_mlier`=0; `mul_mcand`=0; `out_valid`=0; `out_prodt`=0; `out_err`=0; `busy`=0; timer=0.
- **Reset mid-operation:** drops `mul_start` immediately, discards the FIFO contents and any pending result.
- **Issue latency:** a push at edge k into an empty FIFO in IDLE with a free output gives `mul_start`=1 after edge k+1.
- **Result latency:** `mul_valid` first sampled high at edge m gives `out_valid`=1 and `mul_start`=0 after edge m.
- **Back-to-back:** next `mul_start` rises no earlier than after edge m+2, which guarantees a low-start gap of at least one cycle.
- **Timeout:** with `mul_start` rising after edge s and no `mul_valid`, `out_valid`/`out_err` rise after edge s+`TIMEOUT`.
- **Output hold:** `out_prodt` and `out_err` are stable while `out_valid & !out_ready`.

## Test plan
- **Single operation.** Push 1238, 12345; the `multi_vl` model answers after 33 cycles.
  - `out_valid` rises after that edge with `out_prodt`=15283110 and `out_err`=0.
  - `mul_start` is high for exactly 33 cycles.
- **Four-pair burst.** Push (1238,12345), (12,23123), (3234,22122), (8,12399) on consecutive cycles with `out_ready`=1.
  - `in_ready` stays 1.
  - Results appear in order: 15283110, 277476, 71542548, 99192.
  - `mul_start` is low for at least 1 cycle between operations.
- **FIFO full and output back-pressure.** Hold `out_ready`=0 and push 6 pairs.
  - `in_ready`=0 after the 5th accepted push: 4 entries buffered plus 1 already issued.
  - The first result holds unchanged.
  - After `out_ready`=1, all 5 accepted results drain in order and the 6th push is accepted.
- **Timeout.** Use a multiplier stub that never asserts `mul_valid`.
  - `out_valid`=1, `out_err`=1, `out_prodt`=0 after 40 cycles.
  - The next queued pair issues normally.
- **Valid on the timeout cycle.** The stub asserts `mul_valid` exactly at timer=`TIMEOUT`.
  - The product is captured and `out_err`=0.
- **Reset mid-operation.** Assert `reset`=0 for 1 ns during ISSUE with 2 entries queued.
  - `mul_start`=0 and `busy`=0 immediately.
  - No result appears.
  - After release, a fresh push completes normally.
